// File: rtl/bin2bcd_if.sv
// Handshake and digit bundle between a bin2bcd_seq converter and its caller.
// The caller drives start and b_in; the converter returns busy, done and the four BCD digits.
interface bin2bcd_if #(
    parameter int N = 10
);
    logic         start;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic [3:0]   un;
    logic [3:0]   dec;
    logic [3:0]   cent;
    logic [3:0]   mil;

    modport master (output start, b_in, input busy, done, un, dec, cent, mil);
    modport slave  (input start, b_in, output busy, done, un, dec, cent, mil);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble): one add-3/shift iteration per clock,
// four BCD digits latched once N iterations have completed.
module bin2bcd_seq #(
    parameter int N = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    bin2bcd_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam int WW = N + 16;

    if (N < 4 || N > 13) begin : g_bad_n
        $error("bin2bcd_seq: N=%0d outside supported range 4..13", N);
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          r_state;
    logic [WW-1:0]   r_work;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [3:0]      r_un;
    logic [3:0]      r_dec;
    logic [3:0]      r_cent;
    logic [3:0]      r_mil;

    logic [WW-1:0]   w_adj;
    logic [WW-1:0]   w_shift;
    logic            w_last;

    // Add-3 correction on all four nibbles in parallel, then the shift.
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < 4; i++) begin
            if (r_work[N + 4*i +: 4] >= 4'd5) begin
                w_adj[N + 4*i +: 4] = r_work[N + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shift = w_adj << 1;
    assign w_last  = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_un    <= 4'd0;
            r_dec   <= 4'd0;
            r_cent  <= 4'd0;
            r_mil   <= 4'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_work  <= {16'b0, bus.b_in};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_work <= w_shift;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_un    <= w_shift[N      +: 4];
                        r_dec   <= w_shift[N + 4  +: 4];
                        r_cent  <= w_shift[N + 8  +: 4];
                        r_mil   <= w_shift[N + 12 +: 4];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.un   = r_un;
    assign bus.dec  = r_dec;
    assign bus.cent = r_cent;
    assign bus.mil  = r_mil;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected digits, a monitor pops them on done.
module tb_bin2bcd_seq;
    localparam int N = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    bin2bcd_if #(.N(N)) bus ();

    bin2bcd_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bus.mil, bus.cent, bus.dec, bus.un};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.un > 4'd9 || bus.dec > 4'd9 || bus.cent > 4'd9 || bus.mil > 4'd9) begin
                failures++;
                $display("FAIL digit_range actual=%0h required=each digit <= 9", digits());
            end
            if (bus.done) begin
                done_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual=%0h required=no done", digits());
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (digits() !== mon_exp) begin
                        failures++;
                        $display("FAIL result actual=%0h required=%0h", digits(), mon_exp);
                    end
                end
            end
        end
    end

    // Counts edges from the accepting edge until done is seen (sampled 1 time unit after each edge).
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        if (bus.busy) bc++;
        while (!bus.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) bc++;
        end
    endtask

    task automatic convert(input int val, input logic [15:0] exp_bcd);
        int cyc, bc;
        exp_q.push_back(exp_bcd);
        bus.b_in  = N'(val);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, bc);
        check("latency", cyc, N);
        check("busy_cycles", bc, N);
    endtask

    initial begin
        int cyc, bc, bad, d0, v;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        bus.start = 1'b0;
        bus.b_in  = '0;
        #12;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_digits", int'(digits()), 0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        convert(0, 16'h0000);

        convert(1023, 16'h1023);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (digits() !== 16'h1023 || bus.busy || bus.done) bad++;
        end
        check("hold_1023", bad, 0);

        // A start during SHIFT with a new b_in must be ignored.
        d0 = done_cnt;
        exp_q.push_back(16'h0999);
        bus.b_in  = N'(999);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.b_in  = N'(5);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, bc);
        check("ignored_start_latency", cyc + 4, N);
        repeat (15) @(posedge clk);
        #1;
        check("single_done", done_cnt - d0, 1);

        // Back-to-back with start held high.
        exp_q.push_back(16'h0512);
        exp_q.push_back(16'h0037);
        bus.b_in  = N'(512);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.b_in = N'(37);
        wait_done(cyc, bc);
        check("b2b_first_latency", cyc, N);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, bc);
        check("b2b_period", cyc + 1, N + 1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a conversion.
        convert(345, 16'h0345);
        bus.b_in  = N'(1000);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_done", int'(bus.done), 0);
        check("async_rst_digits", int'(digits()), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", int'(bus.busy), 0);
        convert(7, 16'h0007);

        for (int i = 0; i < 200; i++) begin
            v = int'($urandom_range(1023, 0));
            convert(v, {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)});
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble). It takes an N-bit unsigned binary value and produces four BCD digits (units, tens, hundreds, thousands).
- Sits directly upstream of the combinational bcd/7-segment display stage and feeds its digit decoders.
- Replaces a wide combinational divide with one shift per clock. The caller handshakes through start / busy / done.

Parameters:
- N, 10, width of binary input. Legal range 4..13, so the maximum input is ≤ 8191 and fits 4 digits.
- Values outside the range are unsupported and flagged by a simulation-time $error.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a conversion of b_in; sampled on rising clk edge
- b_in  input  N  unsigned binary value; captured only on an accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: result digits just updated
- un  output  4  BCD units digit
- dec  output  4  BCD tens digit
- cent  output  4  BCD hundreds digit
- mil  output  4  BCD thousands digit

Behaviour:

Reset:
- rst_n low forces state=IDLE, busy=0, done=0, un=dec=cent=mil=0, shift register=0, counter=0.
- Reset is asynchronous and takes effect immediately, also mid-conversion. An interrupted conversion is discarded and no done is issued.

State machine (IDLE, SHIFT, DONE):
- IDLE: busy=0, done=0. start=1 at edge k accepts the request.
  - Working register {bcd[15:0], bin[N-1:0]} is loaded with {16'b0, b_in}.
  - Counter is cleared to 0; state -> SHIFT; busy=1 from edge k.
- SHIFT: one iteration per edge. Each iteration:
  - Every 4-bit BCD nibble ≥ 5 gets +3, all nibbles in parallel.
  - The whole {bcd, bin} register is then shifted left by 1, with bin MSB moving into bcd LSB.
  - Counter increments. On the N-th iteration (edge k+N), the post-shift bcd nibbles are latched into un/dec/cent/mil. In the same edge: done=1, busy=0, state -> DONE.
- DONE: lasts exactly one cycle. done falls at edge k+N+1.
  - start=1 at that edge is accepted exactly as in IDLE (back-to-back operation, busy rises at the same edge). Otherwise state -> IDLE.

Latency and holding:
- Latency: done rises N edges after the accepting edge (N=10 -> 10 cycles). Throughput is one conversion per N+1 cycles.
- start while in SHIFT is ignored. b_in changes during SHIFT have no effect because the value was captured at acceptance.
- un/dec/cent/mil hold their last result until the next done edge or reset. They never show intermediate shift values.

Arithmetic and digit rules:
- Unused upper digits read 0. For N=10 the maximum output is mil=1, dec=2, cent=0, un=3 (1023).
- Every digit output is 0..9 at all times. The add-3 step is applied before the shift, never on the final extraction.
- The counter is ceil(log2(N+1)) bits wide and must not wrap within a conversion.

Test Plan:
- Reset then b_in=0, start 1 cycle -> done after exactly 10 edges; mil/cent/dec/un = 0/0/0/0; busy high for 10 cycles.
- b_in=1023, start -> done at edge k+10; digits 1/0/2/3; outputs hold 1/0/2/3 with start low for 20 further cycles.
- b_in=999, start; at edge k+4 set b_in=5 and pulse start -> second start ignored, result 0/9/9/9, exactly one done pulse.
- Back-to-back: start held high continuously, b_in=512 then 37 presented at the accepting edges -> done pulses every 11 cycles, results 0/5/1/2 then 0/0/3/7.
- Convert 345 (digits 0/3/4/5), then start 1000 and assert rst_n=0 at edge k+5 (async, mid-clock) -> immediately busy=0, done=0, all digits 0. After release, converting 7 -> 0/0/0/7.
- Random sweep: 200 random values in 0..1023 via $urandom_range -> each result equals value/1000, (value/100)%10, (value/10)%10, value%10; no digit ever exceeds 9.
